// File: rtl/axis_port_arbiter_if.sv
// axis_port_arbiter_if
//   AXI-Stream bundle of N lanes sharing one signal set. Lane i of the
//   packed data buses lives in slice [i*DATA_W +: DATA_W] (tkeep: DATA_W/8).
//   The arbiter uses one instance with N=NUM_PORTS on the ingress side and
//   one with N=1 on the egress side.
//
// Signals (per lane)
//   tvalid  beat valid             tready  sink ready
//   tdata   payload (DATA_W)       tkeep   byte enables (DATA_W/8)
//   tuser   header word (DATA_W)   tlast   end of packet
//
// Modports
//   master  drives tvalid/tdata/tkeep/tuser/tlast, samples tready
//   slave   samples tvalid/tdata/tkeep/tuser/tlast, drives tready
interface axis_port_arbiter_if #(
  parameter int N      = 1,
  parameter int DATA_W = 64
);
  logic [N-1:0]          tvalid;
  logic [N-1:0]          tready;
  logic [N*DATA_W-1:0]   tdata;
  logic [N*DATA_W/8-1:0] tkeep;
  logic [N*DATA_W-1:0]   tuser;
  logic [N-1:0]          tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/axis_port_arbiter.sv
// axis_port_arbiter
//   Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream ingress
//   ports onto one registered egress stream. A port keeps the grant until its
//   tlast beat is accepted; one arbitration cycle separates packets.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   s_axis         slave bundle, NUM_PORTS lanes (tready driven here)
//   m_axis         master bundle, 1 lane, all payload outputs registered
//   grant_valid    high while a port holds the grant
//   grant_idx      current / most recent granted port
//   pkt_forwarded  count of egress tlast handshakes, wraps at 2^32
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no grant held; arbitrate among valid ports, all tready low
// LOCKED | grant_idx owns the output until its tlast beat is accepted
module axis_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  axis_port_arbiter_if.slave  s_axis,
  axis_port_arbiter_if.master m_axis,
  output logic                grant_valid,
  output logic [2:0]          grant_idx,
  output logic [31:0]         pkt_forwarded
);

  localparam int         KEEP_W    = DATA_W / 8;
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [2:0]           grant_q;
  logic [2:0]           last_grant_q;
  logic [2:0]           arb_winner;
  logic [2:0]           win_hi;
  logic [2:0]           win_lo;
  logic                 found_hi;
  logic                 any_valid;

  logic [NUM_PORTS-1:0] gnt_oh;
  logic                 gnt_valid;
  logic                 gnt_last;
  logic [DATA_W-1:0]    sel_data;
  logic [DATA_W-1:0]    sel_user;
  logic [KEEP_W-1:0]    sel_keep;

  logic                 out_ready;
  logic                 xfer;
  logic                 m_fire_last;
  logic [NUM_PORTS-1:0] s_tready_d;

  logic                 m_tvalid_q;
  logic                 m_tlast_q;
  logic [DATA_W-1:0]    m_tdata_q;
  logic [DATA_W-1:0]    m_tuser_q;
  logic [KEEP_W-1:0]    m_tkeep_q;
  logic [31:0]          pkt_cnt_q;

  // Round-robin pick: the lowest valid index above last_grant wins; if there
  // is none, the lowest valid index at or below it (wrap-around).
  assign any_valid = |s_axis.tvalid;

  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis.tvalid[i]) begin
        if (3'(i) > last_grant_q) begin
          found_hi = 1'b1;
          win_hi   = 3'(i);
        end else begin
          win_lo = 3'(i);
        end
      end
    end
    arb_winner = found_hi ? win_hi : win_lo;
  end

  // Granted-port mux, decoded by compare so no runtime index is needed.
  always_comb begin
    gnt_oh    = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        gnt_valid = s_axis.tvalid[i];
        gnt_last  = s_axis.tlast[i];
        sel_data  = s_axis.tdata[i*DATA_W +: DATA_W];
        sel_user  = s_axis.tuser[i*DATA_W +: DATA_W];
        sel_keep  = s_axis.tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  // Output register can take a new beat when empty or being drained.
  assign out_ready   = !m_tvalid_q || m_axis.tready[0];
  assign xfer        = (state_q == ST_LOCKED) && out_ready && gnt_valid;
  assign m_fire_last = m_tvalid_q && m_axis.tready[0] && m_tlast_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_valid)         state_d = ST_LOCKED;
      ST_LOCKED: if (xfer && gnt_last)  state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready_d  = '0;
    grant_valid = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_valid = 1'b1;
      if (out_ready) s_tready_d = gnt_oh;
    end
  end

  // grant_q and last_grant_q agree whenever the FSM is IDLE; last_grant_q
  // only moves once the packet's final beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= LAST_PORT;
      last_grant_q <= LAST_PORT;
    end else begin
      if (state_q == ST_IDLE && any_valid) grant_q      <= arb_winner;
      if (xfer && gnt_last)                last_grant_q <= grant_q;
    end
  end

  // Payload fields hold when the register drains without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tkeep_q  <= '0;
    end else if (xfer) begin
      m_tvalid_q <= 1'b1;
      m_tlast_q  <= gnt_last;
      m_tdata_q  <= sel_data;
      m_tuser_q  <= sel_user;
      m_tkeep_q  <= sel_keep;
    end else if (out_ready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  // Updated every cycle so the count follows its own current value.
  always_ff @(posedge clk) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_q + 32'(m_fire_last);
  end

  assign s_axis.tready  = s_tready_d;
  assign m_axis.tvalid  = m_tvalid_q;
  assign m_axis.tlast   = m_tlast_q;
  assign m_axis.tdata   = m_tdata_q;
  assign m_axis.tuser   = m_tuser_q;
  assign m_axis.tkeep   = m_tkeep_q;
  assign grant_idx      = grant_q;
  assign pkt_forwarded  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_port_arbiter.sv
// tb_axis_port_arbiter
//   Directed vectors for axis_port_arbiter (4 ports, 64-bit data). Port p
//   carries tdata = {48'h0, p, byte}; tuser/tkeep are derived from p and the
//   byte so the egress port of every beat can be identified.
module tb_axis_port_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic [31:0] pkt_forwarded;

  always #5 clk = ~clk;

  axis_port_arbiter_if #(.N(NP), .DATA_W(DW)) s_if ();
  axis_port_arbiter_if #(.N(1),  .DATA_W(DW)) m_if ();

  axis_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .pkt_forwarded (pkt_forwarded)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        r;
    logic        mr;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;       // {port3, port2, port1, port0} bytes
    logic [3:0]  e_srdy;
    logic        e_mv;
    logic [2:0]  e_mp;
    logic [7:0]  e_mb;
    logic        e_ml;
    logic        e_gv;
    logic [2:0]  e_gi;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] f_data(input int p, input logic [7:0] b);
    f_data = {48'h0, 8'(p), b};
  endfunction

  function automatic logic [DW-1:0] f_user(input int p, input logic [7:0] b);
    f_user = f_data(p, b) ^ 64'h5A5A_0000_0000_0000;
  endfunction

  function automatic logic [KW-1:0] f_keep(input int p);
    logic [KW-1:0] k;
    k = 8'h0F;
    f_keep = k << p;
  endfunction

  function automatic vec_t mk(input logic r, input logic mr, input logic [3:0] v,
                              input logic [3:0] l, input logic [31:0] d,
                              input logic [3:0] srdy, input logic mv, input logic [2:0] mp,
                              input logic [7:0] mb, input logic ml, input logic gv,
                              input logic [2:0] gi, input logic [31:0] cnt);
    vec_t x;
    x.r = r; x.mr = mr; x.v = v; x.l = l; x.d = d;
    x.e_srdy = srdy; x.e_mv = mv; x.e_mp = mp; x.e_mb = mb; x.e_ml = ml;
    x.e_gv = gv; x.e_gi = gi; x.e_cnt = cnt;
    return x;
  endfunction

  task automatic drive(input logic r, input logic mr, input logic [3:0] v,
                       input logic [3:0] l, input logic [31:0] d);
    rst          = r;
    m_if.tready  = mr;
    s_if.tvalid  = v;
    s_if.tlast   = l;
    for (int p = 0; p < NP; p++) begin
      s_if.tdata[p*DW +: DW] = f_data(p, d[p*8 +: 8]);
      s_if.tuser[p*DW +: DW] = f_user(p, d[p*8 +: 8]);
      s_if.tkeep[p*KW +: KW] = f_keep(p);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_vec(input int i, input vec_t x);
    logic bad;
    n_vec++;
    bad = (s_if.tready !== x.e_srdy) || (m_if.tvalid[0] !== x.e_mv) ||
          (grant_valid !== x.e_gv) || (grant_idx !== x.e_gi) || (pkt_forwarded !== x.e_cnt);
    if (x.e_mv)
      bad = bad || (m_if.tdata !== f_data(int'(x.e_mp), x.e_mb)) ||
            (m_if.tuser !== f_user(int'(x.e_mp), x.e_mb)) ||
            (m_if.tkeep !== f_keep(int'(x.e_mp))) || (m_if.tlast[0] !== x.e_ml);
    if (bad) begin
      n_bad++;
      $display("FAIL vec%0d: got srdy=%b mv=%b data=%h last=%b gv=%b gi=%0d cnt=%0d, expected srdy=%b mv=%b data=%h last=%b gv=%b gi=%0d cnt=%0d",
               i, s_if.tready, m_if.tvalid[0], m_if.tdata, m_if.tlast[0], grant_valid, grant_idx,
               pkt_forwarded, x.e_srdy, x.e_mv, f_data(int'(x.e_mp), x.e_mb), x.e_ml, x.e_gv,
               x.e_gi, x.e_cnt);
    end
  endtask

  logic [7:0] rx[$];
  int         beat;
  int         cyc;
  logic       mr;
  logic       src;
  logic       snk;
  logic [7:0] snk_b;

  initial begin
    // Single port 1, three beats (latency N -> N+1 tready -> N+2 tvalid).
    tbl.push_back(mk(1,1,4'b0000,4'b0000,32'h0,          4'b0000,0,0,8'h00,0,0,3,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0000,32'h0000_1100,  4'b0010,0,0,8'h00,0,1,1,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0000,32'h0000_1100,  4'b0010,1,1,8'h11,0,1,1,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0000,32'h0000_2200,  4'b0010,1,1,8'h22,0,1,1,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0010,32'h0000_3300,  4'b0000,1,1,8'h33,1,0,1,0));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0,          4'b0000,0,0,8'h00,0,0,1,1));
    // Round robin over ports 0,1,3 with 2-beat packets from reset.
    tbl.push_back(mk(1,1,4'b0000,4'b0000,32'h0,          4'b0000,0,0,8'h00,0,0,3,0));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B1_A1,4'b0001,0,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B1_A1,4'b0001,1,0,8'hA1,0,1,0,0));
    tbl.push_back(mk(0,1,4'b1011,4'b0001,32'hD1_00_B1_A2,4'b0000,1,0,8'hA2,1,0,0,0));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B1_A3,4'b0010,0,0,8'h00,0,1,1,1));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B1_A3,4'b0010,1,1,8'hB1,0,1,1,1));
    tbl.push_back(mk(0,1,4'b1011,4'b0010,32'hD1_00_B2_A3,4'b0000,1,1,8'hB2,1,0,1,1));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B3_A3,4'b1000,0,0,8'h00,0,1,3,2));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD1_00_B3_A3,4'b1000,1,3,8'hD1,0,1,3,2));
    tbl.push_back(mk(0,1,4'b1011,4'b1000,32'hD2_00_B3_A3,4'b0000,1,3,8'hD2,1,0,3,2));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B3_A3,4'b0001,0,0,8'h00,0,1,0,3));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B3_A3,4'b0001,1,0,8'hA3,0,1,0,3));
    tbl.push_back(mk(0,1,4'b1011,4'b0001,32'hD3_00_B3_A4,4'b0000,1,0,8'hA4,1,0,0,3));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B3_A5,4'b0010,0,0,8'h00,0,1,1,4));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B3_A5,4'b0010,1,1,8'hB3,0,1,1,4));
    tbl.push_back(mk(0,1,4'b1011,4'b0010,32'hD3_00_B4_A5,4'b0000,1,1,8'hB4,1,0,1,4));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B5_A5,4'b1000,0,0,8'h00,0,1,3,5));
    tbl.push_back(mk(0,1,4'b1011,4'b0000,32'hD3_00_B5_A5,4'b1000,1,3,8'hD3,0,1,3,5));
    tbl.push_back(mk(0,1,4'b1011,4'b1000,32'hD4_00_B5_A5,4'b0000,1,3,8'hD4,1,0,3,5));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0,          4'b0000,0,0,8'h00,0,0,3,6));
    // Lock: port 2 holds the grant while port 0 waits; one-cycle gap
    // mid-packet; then port 0 sends a single-beat packet.
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h00_C1_00_00,4'b0100,0,0,8'h00,0,1,2,6));
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h00_C1_00_00,4'b0100,1,2,8'hC1,0,1,2,6));
    tbl.push_back(mk(0,1,4'b0101,4'b0000,32'h00_C2_00_A6,4'b0100,1,2,8'hC2,0,1,2,6));
    tbl.push_back(mk(0,1,4'b0001,4'b0000,32'h00_C3_00_A6,4'b0100,0,0,8'h00,0,1,2,6));
    tbl.push_back(mk(0,1,4'b0101,4'b0000,32'h00_C3_00_A6,4'b0100,1,2,8'hC3,0,1,2,6));
    tbl.push_back(mk(0,1,4'b0101,4'b0100,32'h00_C4_00_A6,4'b0000,1,2,8'hC4,1,0,2,6));
    tbl.push_back(mk(0,1,4'b0001,4'b0001,32'h00_00_00_A6,4'b0001,0,0,8'h00,0,1,0,7));
    tbl.push_back(mk(0,1,4'b0001,4'b0001,32'h00_00_00_A6,4'b0000,1,0,8'hA6,1,0,0,7));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0,          4'b0000,0,0,8'h00,0,0,0,8));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].mr, tbl[i].v, tbl[i].l, tbl[i].d);
      @(posedge clk); #1;
      check_vec(i, tbl[i]);
    end

    // Backpressure: port 1 sends 0x51..0x54, egress stalls cycles 4..8.
    beat = 0;
    cyc  = 0;
    while (rx.size() < 4 && cyc < 40) begin
      mr = !(cyc >= 4 && cyc <= 8);
      drive(0, mr, (beat < 4) ? 4'b0010 : 4'b0000, (beat == 3) ? 4'b0010 : 4'b0000,
            {16'h0, 8'(8'h51 + beat), 8'h0});
      #1;
      if (!mr)
        chk("bp_stall", {m_if.tvalid[0], s_if.tready[1], m_if.tlast[0], m_if.tdata},
            {1'b1, 1'b0, rx.size() == 3, f_data(1, 8'(8'h51 + rx.size()))});
      src   = s_if.tvalid[1] & s_if.tready[1];
      snk   = m_if.tvalid[0] & mr;
      if (snk) begin
        chk("bp_beat", {m_if.tlast[0], m_if.tdata},
            {rx.size() == 3, f_data(1, 8'(8'h51 + rx.size()))});
        snk_b = m_if.tdata[7:0];
      end
      @(posedge clk); #1;
      if (src) beat++;
      if (snk) rx.push_back(snk_b);
      cyc++;
    end
    chk("bp_count", 128'(rx.size()), 128'd4);
    chk("bp_cnt", 128'(pkt_forwarded), 128'd9);

    // Reset after beat 2 of a 4-beat port 2 packet.
    beat = 0;
    cyc  = 0;
    while (beat < 2 && cyc < 20) begin
      drive(0, 1, 4'b0100, 4'b0000, {8'h0, 8'(8'hE1 + beat), 16'h0});
      #1;
      src = s_if.tready[2];
      @(posedge clk); #1;
      if (src) beat++;
      cyc++;
    end
    chk("rst_pre_beats", 128'(beat), 128'd2);
    drive(1, 1, 4'b0101, 4'b0000, 32'h00_E3_00_F1);
    @(posedge clk); #1;
    chk("rst_ctrl", {m_if.tvalid[0], m_if.tlast[0], grant_valid, grant_idx, s_if.tready, pkt_forwarded},
        {1'b0, 1'b0, 1'b0, 3'd3, 4'b0000, 32'd0});
    chk("rst_data", {m_if.tdata, m_if.tuser}, 128'd0);
    chk("rst_keep", 128'(m_if.tkeep), 128'd0);
    drive(0, 1, 4'b0101, 4'b0001, 32'h00_E3_00_F1);
    @(posedge clk); #1;
    chk("rst_first_arb", {grant_valid, grant_idx, s_if.tready, m_if.tvalid[0]},
        {1'b1, 3'd0, 4'b0001, 1'b0});
    @(posedge clk); #1;
    chk("rst_first_beat", {m_if.tvalid[0], m_if.tlast[0], m_if.tdata},
        {1'b1, 1'b1, f_data(0, 8'hF1)});
    drive(0, 1, 4'b0000, 4'b0000, 32'h0);
    @(posedge clk); #1;
    chk("rst_after", {m_if.tvalid[0], grant_valid, pkt_forwarded}, {1'b0, 1'b0, 32'd1});

    // Counter wrap: preload all-ones, forward one single-beat packet.
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    release dut.pkt_cnt_q;
    drive(0, 1, 4'b0010, 4'b0010, 32'h0000_7700);
    @(posedge clk); #1;
    chk("wrap_grant", {grant_valid, grant_idx}, {1'b1, 3'd1});
    @(posedge clk); #1;
    chk("wrap_pre", {m_if.tvalid[0], pkt_forwarded}, {1'b1, 32'hFFFF_FFFF});
    drive(0, 1, 4'b0000, 4'b0000, 32'h0);
    @(posedge clk); #1;
    chk("wrap_zero", 128'(pkt_forwarded), 128'd0);
    @(posedge clk); #1;
    chk("wrap_hold", {m_if.tvalid[0], pkt_forwarded}, {1'b0, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_port_arbiter.md
AXIS_PORT_ARBITER -- requirements
Module: axis_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of ingress port managers sharing the output (2..8).
REQ-002 SHALL have parameter DATA_W, default 64, tdata/tuser width; tkeep width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 s_tvalid  input  NUM_PORTS  per-port beat valid.
REQ-006 s_tdata  input  NUM_PORTS*DATA_W  per-port data; port i in slice [i*DATA_W +: DATA_W].
REQ-007 s_tkeep  input  NUM_PORTS*DATA_W/8  per-port byte enables.
REQ-008 s_tuser  input  NUM_PORTS*DATA_W  per-port header (from ingress port manager).
REQ-009 s_tlast  input  NUM_PORTS  per-port end of packet.
REQ-010 s_tready  output  NUM_PORTS  per-port ready.
REQ-011 m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast  output  1/DATA_W/DATA_W/8/DATA_W/1  registered AXIS output.
REQ-012 m_tready  input  1  downstream ready.
REQ-013 grant_valid  output  1  high while state is LOCKED.
REQ-014 grant_idx  output  3  currently/last granted port index.
REQ-015 pkt_forwarded  output  32  count of output beats with m_tvalid & m_tready & m_tlast.

Function
REQ-016 SHALL implement FSM states IDLE and LOCKED.
REQ-017 IDLE: if any s_tvalid bit set, SHALL select winner by round-robin, priority order (last_grant+1) mod NUM_PORTS upward with wrap; register grant_idx=winner, go LOCKED next edge.
REQ-018 IDLE: all s_tready SHALL be 0; no beat accepted in the arbitration cycle.
REQ-019 LOCKED: s_tready[grant_idx] = out_ready, where out_ready = !m_tvalid || m_tready; all other s_tready bits 0.
REQ-020 Beat transfer SHALL occur when s_tvalid[g] & s_tready[g]; beat registered into m_* on that edge with m_tvalid=1.
REQ-021 If out_ready and no transfer, m_tvalid SHALL clear to 0 on next edge; other m_* fields may hold.
REQ-022 While m_tvalid=1 and m_tready=0, all m_* outputs SHALL hold stable.
REQ-023 Transfer with s_tlast=1 SHALL set last_grant=g and return to IDLE on the same edge.
REQ-024 Grant SHALL not change mid-packet regardless of other ports' s_tvalid.
REQ-025 LOCKED with granted s_tvalid=0 SHALL remain LOCKED (gap tolerated, no timeout).
REQ-026 Latency: s_tvalid rising at cycle N in IDLE with m_tready=1 -> s_tready high in cycle N+1 -> m_tvalid high in cycle N+2.
REQ-027 Throughput: 1 beat/cycle within a packet; exactly one IDLE cycle between consecutive packets.
REQ-028 Single-beat packet (tlast on first beat) SHALL be handled identically.
REQ-029 pkt_forwarded SHALL increment by 1 per REQ-015 event and wrap 0xFFFFFFFF -> 0.
REQ-030 grant_idx SHALL retain its value in IDLE until the next arbitration.

Reset
REQ-031 rst=1 at any edge SHALL force: state IDLE, m_tvalid=0, m_tlast=0, m_tdata/tkeep/tuser=0, grant_valid=0, grant_idx=NUM_PORTS-1, last_grant=NUM_PORTS-1 (port 0 highest priority), pkt_forwarded=0, s_tready=0.
REQ-032 Reset mid-packet SHALL discard the partial packet; no beat of it appears after reset deasserts.
REQ-033 First arbitration SHALL occur in the first cycle with rst=0.

Verification
REQ-034 Single port: port 1 sends 3-beat packet, data 0x11,0x22,0x33, m_tready=1 -> m_* shows same beats cycles N+2..N+4, tlast on 0x33, pkt_forwarded=1.
REQ-035 Round-robin: ports 0,1,3 all valid with 2-beat packets continuously -> output packet order 0,1,3,0,1,3; one IDLE cycle between packets.
REQ-036 Lock: port 2 granted mid 4-beat packet, port 0 asserts valid -> port 0 s_tready stays 0 until port 2 tlast accepted; port 0 granted next.
REQ-037 Backpressure: m_tready=0 for 5 cycles mid-packet -> m_* stable, s_tready[g]=0, no beat lost/duplicated after release.
REQ-038 Reset mid-packet: rst=1 after beat 2 of 4 -> all outputs at reset values next cycle; after release port 0 wins if valid.
REQ-039 Counter wrap: preload/force pkt_forwarded=0xFFFFFFFF, forward one packet -> 0x00000000.
